// File: rtl/msrv32_trap_pkg.sv
// Shared constants for the msrv32 machine-mode trap sequencer: FSM encodings,
// mcause codes and the SYSTEM-instruction fields used to spot ECALL/EBREAK/MRET.
package msrv32_trap_pkg;

    localparam logic [1:0] RESET       = 2'b00;
    localparam logic [1:0] OPERATING   = 2'b01;
    localparam logic [1:0] TRAP_TAKEN  = 2'b10;
    localparam logic [1:0] TRAP_RETURN = 2'b11;

    localparam logic [3:0] EXC_MISALIGNED_INSTR = 4'd0;
    localparam logic [3:0] EXC_ILLEGAL          = 4'd2;
    localparam logic [3:0] EXC_BREAKPOINT       = 4'd3;
    localparam logic [3:0] EXC_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] EXC_STORE_MISALIGNED = 4'd6;
    localparam logic [3:0] EXC_ECALL_M          = 4'd11;
    localparam logic [3:0] INT_MSI              = 4'd3;
    localparam logic [3:0] INT_MTI              = 4'd7;
    localparam logic [3:0] INT_MEI              = 4'd11;

    localparam logic [4:0] OPCODE_SYSTEM = 5'b11100;
    localparam logic [6:0] FUNCT7_MRET   = 7'b0011000;
    localparam logic [4:0] RS2_MRET      = 5'b00010;
    localparam logic [4:0] RS2_EBREAK    = 5'b00001;

    localparam logic [1:0] PC_BOOT  = 2'b00;
    localparam logic [1:0] PC_SEQ   = 2'b01;
    localparam logic [1:0] PC_MTVEC = 2'b10;
    localparam logic [1:0] PC_MEPC  = 2'b11;

    // PRIV-class SYSTEM instruction: funct3 zero with no register operands.
    function automatic logic is_system(input logic [4:0] opcode,
                                       input logic [2:0] funct3,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rd);
        return (opcode == OPCODE_SYSTEM) && (funct3 == 3'b000) &&
               (rs1 == 5'd0) && (rd == 5'd0);
    endfunction

endpackage

// File: rtl/msrv32_trap_prio.sv
// Combinational trap priority encoder: interrupts beat exceptions, and the
// winning source selects the mcause code reported on trap entry.
module msrv32_trap_prio
    import msrv32_trap_pkg::*;
(
    input  logic       sys,
    input  logic [6:0] funct7,
    input  logic [4:0] rs2_addr,
    input  logic       illegal_instr,
    input  logic       misaligned_load,
    input  logic       misaligned_store,
    input  logic       misaligned_instr,
    input  logic       mie,
    input  logic       meie,
    input  logic       mtie,
    input  logic       msie,
    input  logic       meip,
    input  logic       mtip,
    input  logic       msip,
    output logic       trap,
    output logic       i_or_e,
    output logic [3:0] cause
);

    logic ecall;
    logic ebreak;
    logic ext_irq;
    logic sw_irq;
    logic tmr_irq;
    logic exc;

    assign ecall   = sys && (funct7 == 7'd0) && (rs2_addr == 5'd0);
    assign ebreak  = sys && (funct7 == 7'd0) && (rs2_addr == RS2_EBREAK);
    assign ext_irq = mie && meie && meip;
    assign sw_irq  = mie && msie && msip;
    assign tmr_irq = mie && mtie && mtip;
    assign exc     = misaligned_instr | illegal_instr | ecall | ebreak |
                     misaligned_load | misaligned_store;

    assign trap = ext_irq | sw_irq | tmr_irq | exc;

    always_comb begin
        i_or_e = 1'b0;
        cause  = 4'd0;
        if (ext_irq) begin
            i_or_e = 1'b1;
            cause  = INT_MEI;
        end else if (sw_irq) begin
            i_or_e = 1'b1;
            cause  = INT_MSI;
        end else if (tmr_irq) begin
            i_or_e = 1'b1;
            cause  = INT_MTI;
        end else if (misaligned_instr) begin
            cause = EXC_MISALIGNED_INSTR;
        end else if (illegal_instr) begin
            cause = EXC_ILLEGAL;
        end else if (ebreak) begin
            cause = EXC_BREAKPOINT;
        end else if (ecall) begin
            cause = EXC_ECALL_M;
        end else if (misaligned_store) begin
            cause = EXC_STORE_MISALIGNED;
        end else if (misaligned_load) begin
            cause = EXC_LOAD_MISALIGNED;
        end
    end

endmodule

// File: rtl/msrv32_trap_ctrl.sv
// Machine-mode trap sequencer: trap entry (EPC/cause capture, MIE clear,
// mtvec redirect) and MRET return (MIE restore, mepc redirect).
//
//   state       | meaning
//   RESET       | held in reset, PC from boot vector, pipeline flushed
//   OPERATING   | normal execution, traps and MRET accepted here only
//   TRAP_TAKEN  | one-cycle CSR capture strobes, redirect to mtvec
//   TRAP_RETURN | one-cycle MIE restore, redirect to mepc
module msrv32_trap_ctrl
    import msrv32_trap_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic [4:0] opcode_6_to_2_in,
    input  logic [2:0] funct3_in,
    input  logic [6:0] funct7_in,
    input  logic [4:0] rs1_addr_in,
    input  logic [4:0] rs2_addr_in,
    input  logic [4:0] rd_addr_in,
    input  logic       illegal_instr_in,
    input  logic       misaligned_load_in,
    input  logic       misaligned_store_in,
    input  logic       misaligned_instr_in,
    input  logic       mie_in,
    input  logic       meie_in,
    input  logic       mtie_in,
    input  logic       msie_in,
    input  logic       meip_in,
    input  logic       mtip_in,
    input  logic       msip_in,
    output logic       trap_taken_out,
    output logic       i_or_e_out,
    output logic [3:0] cause_out,
    output logic       set_epc_out,
    output logic       set_cause_out,
    output logic       mie_clear_out,
    output logic       mie_set_out,
    output logic [1:0] pc_src_out,
    output logic       flush_out,
    output logic       instret_inc_out
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       sys;
    logic       mret;
    logic       trap;
    logic       trap_i_or_e;
    logic [3:0] trap_cause;

    assign sys  = is_system(opcode_6_to_2_in, funct3_in, rs1_addr_in, rd_addr_in);
    assign mret = sys && (funct7_in == FUNCT7_MRET) && (rs2_addr_in == RS2_MRET);

    msrv32_trap_prio u_prio (
        .sys              (sys),
        .funct7           (funct7_in),
        .rs2_addr         (rs2_addr_in),
        .illegal_instr    (illegal_instr_in),
        .misaligned_load  (misaligned_load_in),
        .misaligned_store (misaligned_store_in),
        .misaligned_instr (misaligned_instr_in),
        .mie              (mie_in),
        .meie             (meie_in),
        .mtie             (mtie_in),
        .msie             (msie_in),
        .meip             (meip_in),
        .mtip             (mtip_in),
        .msip             (msip_in),
        .trap             (trap),
        .i_or_e           (trap_i_or_e),
        .cause            (trap_cause)
    );

    // Mealy so the decoder can kill a store in the same cycle the trap is seen.
    assign trap_taken_out = (state == OPERATING) && trap;

    always_comb begin
        state_nxt = state;
        case (state)
            RESET:       state_nxt = OPERATING;
            OPERATING: begin
                if (trap)
                    state_nxt = TRAP_TAKEN;
                else if (mret)
                    state_nxt = TRAP_RETURN;
            end
            TRAP_TAKEN:  state_nxt = OPERATING;
            TRAP_RETURN: state_nxt = OPERATING;
            default:     state_nxt = RESET;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= RESET;
            cause_out  <= 4'd0;
            i_or_e_out <= 1'b0;
        end else begin
            state <= state_nxt;
            if (trap_taken_out) begin
                cause_out  <= trap_cause;
                i_or_e_out <= trap_i_or_e;
            end
        end
    end

    always_comb begin
        set_epc_out     = 1'b0;
        set_cause_out   = 1'b0;
        mie_clear_out   = 1'b0;
        mie_set_out     = 1'b0;
        pc_src_out      = PC_BOOT;
        flush_out       = 1'b1;
        instret_inc_out = 1'b0;
        case (state)
            OPERATING: begin
                pc_src_out      = PC_SEQ;
                flush_out       = 1'b0;
                instret_inc_out = ~trap;
            end
            TRAP_TAKEN: begin
                set_epc_out   = 1'b1;
                set_cause_out = 1'b1;
                mie_clear_out = 1'b1;
                pc_src_out    = PC_MTVEC;
            end
            TRAP_RETURN: begin
                mie_set_out = 1'b1;
                pc_src_out  = PC_MEPC;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_msrv32_trap_ctrl.sv
// Directed bench for msrv32_trap_ctrl: reset, exception/interrupt entry,
// priority, MRET return, masked interrupts and reset in the middle of a trap.
module tb_msrv32_trap_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic [4:0] opcode_6_to_2_in;
    logic [2:0] funct3_in;
    logic [6:0] funct7_in;
    logic [4:0] rs1_addr_in;
    logic [4:0] rs2_addr_in;
    logic [4:0] rd_addr_in;
    logic       illegal_instr_in;
    logic       misaligned_load_in;
    logic       misaligned_store_in;
    logic       misaligned_instr_in;
    logic       mie_in;
    logic       meie_in;
    logic       mtie_in;
    logic       msie_in;
    logic       meip_in;
    logic       mtip_in;
    logic       msip_in;
    logic       trap_taken_out;
    logic       i_or_e_out;
    logic [3:0] cause_out;
    logic       set_epc_out;
    logic       set_cause_out;
    logic       mie_clear_out;
    logic       mie_set_out;
    logic [1:0] pc_src_out;
    logic       flush_out;
    logic       instret_inc_out;

    int n_checks = 0;
    int n_pass   = 0;

    msrv32_trap_ctrl dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .opcode_6_to_2_in    (opcode_6_to_2_in),
        .funct3_in           (funct3_in),
        .funct7_in           (funct7_in),
        .rs1_addr_in         (rs1_addr_in),
        .rs2_addr_in         (rs2_addr_in),
        .rd_addr_in          (rd_addr_in),
        .illegal_instr_in    (illegal_instr_in),
        .misaligned_load_in  (misaligned_load_in),
        .misaligned_store_in (misaligned_store_in),
        .misaligned_instr_in (misaligned_instr_in),
        .mie_in              (mie_in),
        .meie_in             (meie_in),
        .mtie_in             (mtie_in),
        .msie_in             (msie_in),
        .meip_in             (meip_in),
        .mtip_in             (mtip_in),
        .msip_in             (msip_in),
        .trap_taken_out      (trap_taken_out),
        .i_or_e_out          (i_or_e_out),
        .cause_out           (cause_out),
        .set_epc_out         (set_epc_out),
        .set_cause_out       (set_cause_out),
        .mie_clear_out       (mie_clear_out),
        .mie_set_out         (mie_set_out),
        .pc_src_out          (pc_src_out),
        .flush_out           (flush_out),
        .instret_inc_out     (instret_inc_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        opcode_6_to_2_in    = 5'b01100;
        funct3_in           = 3'd0;
        funct7_in           = 7'd0;
        rs1_addr_in         = 5'd1;
        rs2_addr_in         = 5'd2;
        rd_addr_in          = 5'd3;
        illegal_instr_in    = 1'b0;
        misaligned_load_in  = 1'b0;
        misaligned_store_in = 1'b0;
        misaligned_instr_in = 1'b0;
        mie_in              = 1'b0;
        meie_in             = 1'b0;
        mtie_in             = 1'b0;
        msie_in             = 1'b0;
        meip_in             = 1'b0;
        mtip_in             = 1'b0;
        msip_in             = 1'b0;
    endtask

    task automatic sys_instr(input logic [6:0] f7, input logic [4:0] rs2);
        opcode_6_to_2_in = 5'b11100;
        funct3_in        = 3'd0;
        rs1_addr_in      = 5'd0;
        rd_addr_in       = 5'd0;
        funct7_in        = f7;
        rs2_addr_in      = rs2;
    endtask

    // Applies the current inputs in OPERATING, expects a trap, then checks the
    // TRAP_TAKEN cycle and the return to OPERATING.
    task automatic trap_seq(input string tag, input logic [3:0] cause, input logic ioe);
        #1;
        chk({tag, "_taken"}, trap_taken_out, 1'b1);
        chk({tag, "_noret"}, instret_inc_out, 1'b0);
        @(negedge clk_in);
        chk({tag, "_epc"}, set_epc_out, 1'b1);
        chk({tag, "_setc"}, set_cause_out, 1'b1);
        chk({tag, "_mieclr"}, mie_clear_out, 1'b1);
        chk({tag, "_pc"}, pc_src_out, 2'b10);
        chk({tag, "_flush"}, flush_out, 1'b1);
        chk({tag, "_cause"}, cause_out, cause);
        chk({tag, "_ioe"}, i_or_e_out, ioe);
        chk({tag, "_ignored"}, trap_taken_out, 1'b0);
        idle_inputs();
        @(negedge clk_in);
        chk({tag, "_back"}, pc_src_out, 2'b01);
        chk({tag, "_hold"}, cause_out, cause);
    endtask

    initial begin
        idle_inputs();
        rst_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
        chk("rst_pc", pc_src_out, 2'b00);
        chk("rst_flush", flush_out, 1'b1);
        chk("rst_cause", cause_out, 4'd0);
        chk("rst_ioe", i_or_e_out, 1'b0);
        chk("rst_epc", set_epc_out, 1'b0);
        illegal_instr_in = 1'b1;
        #1;
        chk("rst_no_trap", trap_taken_out, 1'b0);
        idle_inputs();
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("op_pc", pc_src_out, 2'b01);
        chk("op_flush", flush_out, 1'b0);
        chk("op_instret", instret_inc_out, 1'b1);
        chk("op_cause", cause_out, 4'd0);

        illegal_instr_in = 1'b1;
        trap_seq("illegal", 4'd2, 1'b0);

        mie_in = 1'b1; meie_in = 1'b1; meip_in = 1'b1; misaligned_store_in = 1'b1;
        trap_seq("mei_vs_store", 4'd11, 1'b1);

        mie_in = 1'b1; msie_in = 1'b1; msip_in = 1'b1; mtie_in = 1'b1; mtip_in = 1'b1;
        trap_seq("msi_vs_mti", 4'd3, 1'b1);

        misaligned_instr_in = 1'b1; illegal_instr_in = 1'b1; misaligned_load_in = 1'b1;
        trap_seq("mis_instr", 4'd0, 1'b0);

        sys_instr(7'd0, 5'd1);
        trap_seq("ebreak", 4'd3, 1'b0);

        misaligned_load_in = 1'b1;
        trap_seq("mis_load", 4'd4, 1'b0);

        sys_instr(7'b0011000, 5'b00010);
        #1;
        chk("mret_no_trap", trap_taken_out, 1'b0);
        @(negedge clk_in);
        chk("mret_mieset", mie_set_out, 1'b1);
        chk("mret_pc", pc_src_out, 2'b11);
        chk("mret_flush", flush_out, 1'b1);
        chk("mret_setc", set_cause_out, 1'b0);
        chk("mret_epc", set_epc_out, 1'b0);
        chk("mret_cause", cause_out, 4'd4);
        idle_inputs();
        @(negedge clk_in);
        chk("mret_back", pc_src_out, 2'b01);

        sys_instr(7'b0011000, 5'b00010);
        misaligned_store_in = 1'b1;
        trap_seq("store_over_mret", 4'd6, 1'b0);

        mtie_in = 1'b1; mtip_in = 1'b1; mie_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("masked_trap", trap_taken_out, 1'b0);
            chk("masked_instret", instret_inc_out, 1'b1);
            @(negedge clk_in);
            chk("masked_pc", pc_src_out, 2'b01);
        end
        idle_inputs();

        sys_instr(7'd0, 5'd0);
        #1;
        chk("ecall_taken", trap_taken_out, 1'b1);
        @(negedge clk_in);
        chk("ecall_epc", set_epc_out, 1'b1);
        chk("ecall_cause", cause_out, 4'd11);
        idle_inputs();
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("midrst_epc", set_epc_out, 1'b0);
        chk("midrst_setc", set_cause_out, 1'b0);
        chk("midrst_mieclr", mie_clear_out, 1'b0);
        chk("midrst_pc", pc_src_out, 2'b00);
        chk("midrst_flush", flush_out, 1'b1);
        chk("midrst_cause", cause_out, 4'd0);
        @(negedge clk_in);
        chk("midrst_hold_pc", pc_src_out, 2'b00);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("rel_pc", pc_src_out, 2'b01);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/msrv32_trap_ctrl.md
# msrv32_trap_ctrl

Machine-mode trap sequencer for the msrv32 two-stage core. Collects synchronous exceptions from the decoder and the fetch path, plus the enabled machine interrupts. It runs a four-state FSM that sequences trap entry (EPC/cause capture, MIE clear, vector redirect) and MRET return (MIE restore, EPC redirect). It also drives the decoder's trap_taken_in and the PC source select.

## Interface
No parameters.
- clk_in  input  1  core clock; all state on rising edge
- rst_n_in  input  1  asynchronous, active-low reset
- opcode_6_to_2_in  input  5  opcode[6:2] of instruction in execute stage
- funct3_in  input  3  instruction funct3
- funct7_in  input  7  instruction[31:25]
- rs1_addr_in, rs2_addr_in, rd_addr_in  input  5 each  instruction register fields
- illegal_instr_in  input  1  from decoder
- misaligned_load_in, misaligned_store_in  input  1 each  from decoder
- misaligned_instr_in  input  1  fetch target not 4-byte aligned
- mie_in  input  1  mstatus.MIE
- meie_in, mtie_in, msie_in  input  1 each  mie register enables
- meip_in, mtip_in, msip_in  input  1 each  interrupt pending lines (level)
- trap_taken_out  output  1  trap accepted this cycle (Mealy, to decoder)
- i_or_e_out  output  1  registered: 1 = interrupt, 0 = exception
- cause_out  output  4  registered mcause code
- set_epc_out, set_cause_out, mie_clear_out  output  1 each  CSR update strobes
- mie_set_out  output  1  restore MIE on MRET
- pc_src_out  output  2  00 boot, 01 sequential/branch, 10 mtvec, 11 mepc
- flush_out  output  1  kill instruction in fetch/execute
- instret_inc_out  output  1  retire strobe for minstret

## Operation
- States: RESET=2'b00, OPERATING=2'b01, TRAP_TAKEN=2'b10, TRAP_RETURN=2'b11.
- System decode:
  - sys = opcode_6_to_2_in==5'b11100 & funct3_in==0 & rs1_addr_in==0 & rd_addr_in==0.
  - ecall: sys, funct7 0, rs2 0.
  - ebreak: sys, funct7 0, rs2 1.
  - mret: sys, funct7 7'b0011000, rs2 5'b00010.
- Interrupt pending irq = mie_in & ((meie_in&meip_in) | (msie_in&msip_in) | (mtie_in&mtip_in)).
- Exception exc = misaligned_instr | illegal | ecall | ebreak | misaligned_load | misaligned_store.
- Priority, highest first; this sets the captured cause:
  - interrupts: external (11), software (3), timer (7);
  - then exceptions: misaligned instr (0), illegal (2), ebreak (3), ecall (11), misaligned store (6), misaligned load (4).
- Transitions:
  - RESET→OPERATING unconditionally.
  - OPERATING→TRAP_TAKEN if irq|exc.
  - OPERATING→TRAP_RETURN if mret and no trap. A trap wins over mret.
  - Otherwise OPERATING holds.
  - TRAP_TAKEN→OPERATING and TRAP_RETURN→OPERATING unconditionally.
- trap_taken_out = (state==OPERATING) & (irq|exc). It is combinational, so the decoder suppresses mem_wr_req the same cycle.
- cause_out/i_or_e_out are loaded on the OPERATING→TRAP_TAKEN edge and hold until the next trap.
- Outputs by state:
  - RESET: pc_src 00, flush 1.
  - OPERATING: pc_src 01, flush 0, instret_inc = ~(irq|exc).
  - TRAP_TAKEN: set_epc, set_cause, mie_clear = 1; pc_src 10; flush 1.
  - TRAP_RETURN: mie_set 1; pc_src 11; flush 1.
  - All strobes not listed for a state are 0.

## Timing
- Reset (rst_n_in low, asynchronous):
  - state=RESET, cause_out=0, i_or_e_out=0.
  - Combinational outputs per RESET: pc_src 00, flush 1, all strobes 0.
- Reset deassertion: first rising edge moves to OPERATING.
- Trap latency:
  - trap_taken_out in cycle N;
  - TRAP_TAKEN strobes and the mtvec redirect in N+1;
  - OPERATING in N+2.
- MRET latency: TRAP_RETURN in N+1, OPERATING in N+2.
- Inputs in TRAP_TAKEN/TRAP_RETURN/RESET are ignored; no trap is accepted there.
- Interrupt pending on the same cycle as an exception: the interrupt is taken; the exception re-fires after return.
- Reset mid-trap: the FSM returns to RESET immediately; no CSR strobe is emitted after reset asserts.

## Structure
- Package msrv32_trap_pkg:
  - state localparams;
  - mcause code constants (EXC_MISALIGNED_INSTR=0, EXC_ILLEGAL=2, EXC_BREAKPOINT=3, EXC_LOAD_MISALIGNED=4, EXC_STORE_MISALIGNED=6, EXC_ECALL_M=11, INT_MSI=3, INT_MTI=7, INT_MEI=11);
  - SYSTEM opcode and MRET funct7/rs2 constants.
- Sub-module msrv32_trap_prio: combinational priority encoder producing {trap, i_or_e, cause[3:0]}.
- The top holds the FSM and the cause registers.

## Test plan
- Reset, then release: pc_src 00 + flush 1 during reset; one cycle later pc_src 01; cause_out 0.
- illegal_instr_in=1 in OPERATING:
  - trap_taken_out=1 same cycle;
  - next cycle set_epc/set_cause/mie_clear=1, pc_src 10, cause_out 2, i_or_e 0;
  - then OPERATING.
- mie_in=1, meie_in=meip_in=1 together with misaligned_store_in=1: cause_out 11, i_or_e 1; the store is suppressed via trap_taken_out.
- MRET encoding (0x30200073 fields): TRAP_RETURN next cycle with mie_set 1, pc_src 11, flush 1; no CSR cause write.
- mtip_in=1 with mtie_in=1, mie_in=0: no trap; instret_inc_out=1 each cycle.
- ecall, then rst_n_in asserted during TRAP_TAKEN: all strobes drop asynchronously; state RESET; cause_out 0.
